// File: rtl/spi_pkg.sv
// Shared SPI master definitions: opcodes, controller states and frame geometry.
package spi_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int CNT_W      = 5;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_RW,
    ST_SHIFT,
    ST_WAIT,
    ST_RX,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_master_shreg.sv
// Frame shift-out (parallel load, MSB first) and MISO shift-in capture (MSB first).
// o_cap_next is the capture register with the current MISO bit appended, for same-edge byte pickup.
module spi_master_shreg
  import spi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic [FRAME_BITS-1:0] i_frame,
  input  logic                 i_shift,
  input  logic                 i_cap,
  input  logic                 i_miso,
  output logic                 o_msb,
  output logic [DATA_BITS-1:0] o_cap_next
);

  logic [FRAME_BITS-1:0] r_tx;
  logic [DATA_BITS-1:0]  r_rx;

  assign o_msb      = r_tx[FRAME_BITS-1];
  assign o_cap_next = {r_rx[DATA_BITS-2:0], i_miso};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx <= '0;
      r_rx <= '0;
    end else begin
      if (i_load) begin
        r_tx <= i_frame;
        r_rx <= '0;
      end else if (i_shift) begin
        r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
      end
      if (i_cap) begin
        r_rx <= o_cap_next;
      end
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: one command per frame (SEL, RW, 10 payload bits, then RD_LAT wait + 8 RX bits for op 11).
// cmd_ready only in IDLE; SPI_MASTER_ORDER_CHK_EN enables op-order checking with an err pulse on rejection.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int GAP    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       done,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       err,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] RX_LAST    = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_op;
  logic                 r_ss_n;
  logic                 r_mosi;
  logic                 r_cmd_ready;
  logic                 r_done;
  logic                 r_rx_valid;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_reject;
  logic                 w_msb;
  logic [DATA_BITS-1:0] w_cap_next;

  assign cmd_ready = r_cmd_ready;
  assign done      = r_done;
  assign rx_valid  = r_rx_valid;
  assign rx_data   = r_rx_data;
  assign err       = r_err;
  assign SS_n      = r_ss_n;
  assign MOSI      = r_mosi;

  assign w_accept = cmd_valid && r_cmd_ready;

`ifdef SPI_MASTER_ORDER_CHK_EN
  // Previous sent op; r_prev_vld=0 means "none" (after reset), so data ops are rejected.
  logic       r_prev_vld;
  logic [1:0] r_prev_op;

  assign w_reject = ((cmd_op == OP_WR_DATA) && !(r_prev_vld && (r_prev_op == OP_WR_ADDR))) ||
                    ((cmd_op == OP_RD_DATA) && !(r_prev_vld && (r_prev_op == OP_RD_ADDR)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_vld <= 1'b0;
      r_prev_op  <= OP_WR_ADDR;
    end else if (w_accept && !w_reject) begin
      r_prev_vld <= 1'b1;
      r_prev_op  <= cmd_op;
    end
  end
`else
  assign w_reject = 1'b0;
`endif

  spi_master_shreg u_shreg (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == ST_IDLE),
    .i_frame    ({cmd_op, cmd_data}),
    .i_shift    ((r_state == ST_RW) || (r_state == ST_SHIFT)),
    .i_cap      (r_state == ST_RX),
    .i_miso     (MISO),
    .o_msb      (w_msb),
    .o_cap_next (w_cap_next)
  );

  // Outputs are registered for the state being entered, so each takes effect the cycle after the decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_WR_ADDR;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_reject) begin
              r_err <= 1'b1;
            end else begin
              r_state     <= ST_SEL;
              r_op        <= cmd_op;
              r_ss_n      <= 1'b0;
              r_mosi      <= 1'b0;
              r_cmd_ready <= 1'b0;
            end
          end
        end
        ST_SEL: begin
          r_state <= ST_RW;
          r_mosi  <= r_op[1];
        end
        ST_RW: begin
          r_state <= ST_SHIFT;
          r_mosi  <= w_msb;
          r_cnt   <= '0;
        end
        ST_SHIFT: begin
          if (r_cnt == SHIFT_LAST) begin
            r_cnt  <= '0;
            r_mosi <= 1'b0;
            if (r_op == OP_RD_DATA) begin
              r_state <= (RD_LAT == 0) ? ST_RX : ST_WAIT;
            end else begin
              r_state <= ST_GAP;
              r_ss_n  <= 1'b1;
              r_done  <= 1'b1;
            end
          end else begin
            r_mosi <= w_msb;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (r_cnt == WAIT_LAST) begin
            r_state <= ST_RX;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RX: begin
          if (r_cnt == RX_LAST) begin
            r_state    <= ST_GAP;
            r_cnt      <= '0;
            r_ss_n     <= 1'b1;
            r_done     <= 1'b1;
            r_rx_valid <= 1'b1;
            r_rx_data  <= w_cap_next;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_ss_n      <= 1'b1;
          r_mosi      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl with a behavioural SPI slave + RAM on the far side.
module tb_spi_master_ctrl;

  localparam int RD_LAT = 2;
  localparam int GAP    = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       MISO = 1'b0;
  logic       cmd_ready, done, rx_valid, err, SS_n, MOSI;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_master_ctrl #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .done      (done),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .err       (err),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  typedef struct {
    logic [21:0] seq;
    int          len;
    bit          rd;
    logic [7:0]  rx;
  } exp_t;

  exp_t exp_q[$];
  bit   err_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   n_sent = 0;
  bit   gap_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, got, want, $time);
  endtask

  task automatic fail(input string nm);
    n_chk++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // MOSI bits per frame: SEL(0), RW(op[1]), op[1:0], data[7:0]; read frames add RD_LAT+8 zero bits.
  task automatic push_frame(input logic [11:0] bits, input bit rd, input logic [7:0] rx);
    exp_t e;
    e.rd  = rd;
    e.rx  = rx;
    e.len = rd ? (12 + RD_LAT + 8) : 12;
    e.seq = rd ? (22'(bits) << (RD_LAT + 8)) : 22'(bits);
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d, input bit hold);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    while (!ok && t < 300) begin
      @(negedge clk);
      if (cmd_ready && !rst) ok = 1'b1;
      t++;
    end
    if (!ok) fail("send_timeout");
    @(posedge clk);
    #1;
    if (ok) n_sent++;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Slave model: counts SS_n-low cycles, decodes the frame after 12 bits, serves RAM bytes on MISO.
  logic [7:0]  ram [256];
  logic [11:0] slv_bits = '0;
  int          sidx = 0;
  bit          rd_go = 1'b0;
  logic [7:0]  rd_byte = 8'h00;
  logic [7:0]  wr_addr = 8'h00;
  logic [7:0]  rd_addr = 8'h00;

  always @(posedge clk) begin
    if (SS_n) begin
      sidx  = 0;
      rd_go = 1'b0;
    end else begin
      slv_bits = {slv_bits[10:0], MOSI};
      sidx++;
      if (sidx == 12) begin
        case (slv_bits[9:8])
          2'b00: wr_addr = slv_bits[7:0];
          2'b01: ram[wr_addr] = slv_bits[7:0];
          2'b10: rd_addr = slv_bits[7:0];
          default: begin
            rd_byte = ram[rd_addr];
            rd_go   = 1'b1;
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!SS_n && rd_go && sidx >= 12 + RD_LAT && sidx < 20 + RD_LAT)
      MISO = rd_byte[19 + RD_LAT - sidx];
    else
      MISO = 1'b0;
  end

  // Monitor: pops the scoreboard at every done pulse.
  int          ncyc = 0;
  int          low = 0;
  logic [21:0] seq = '0;
  int          last_done = 0;
  int          n_acc = 0;
  int          busy_viol = 0;
  bit          gap_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (rst) begin
      low = 0;
      seq = '0;
    end else begin
      if (!SS_n) begin
        low++;
        seq = {seq[20:0], MOSI};
        if (cmd_ready) busy_viol++;
      end
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        if (gap_req && !gap_done) begin
          chk("b2b_gap", ncyc - last_done, GAP);
          gap_done = 1'b1;
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          chk("ss_low_len", low, e.len);
          chk("mosi_seq", 32'(seq), 32'(e.seq));
          chk("done_ss_n", SS_n, 1);
          chk("rx_valid", rx_valid, e.rd);
          if (e.rd) chk("rx_data", rx_data, e.rx);
        end
        low = 0;
        seq = '0;
        last_done = ncyc;
      end else if (rx_valid) begin
        fail("rx_valid_without_done");
      end
      if (err) begin
        if (err_q.size() == 0) fail("unexpected_err");
        else begin
          void'(err_q.pop_front());
          chk("err_ss_n", SS_n, 1);
        end
      end
    end
  end

  initial begin
    // Reset with random cmd_valid; valid forced high on the edge where reset is last sampled.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      cmd_valid = (i == 4) ? 1'b1 : 1'(($urandom_range(0, 1)));
    end
    @(negedge clk);
    chk("rst_ss_n", SS_n, 1);
    chk("rst_mosi", MOSI, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("no_accept_at_rst_release", SS_n, 1);
    @(posedge clk);
    #1;

    push_frame(12'h0FE, 1'b0, 8'h00); send(2'b00, 8'hFE, 1'b0);
    push_frame(12'h1AA, 1'b0, 8'h00); send(2'b01, 8'hAA, 1'b0);
    push_frame(12'h6FE, 1'b0, 8'h00); send(2'b10, 8'hFE, 1'b0);
    push_frame(12'h7F0, 1'b1, 8'hAA); send(2'b11, 8'hF0, 1'b0);
    drain();

    // Back-to-back with cmd_valid held high across the first frame.
    push_frame(12'h03C, 1'b0, 8'h00); send(2'b00, 8'h3C, 1'b1);
    gap_req = 1'b1;
    push_frame(12'h05A, 1'b0, 8'h00); send(2'b00, 8'h5A, 1'b0);
    drain();

    // Reset during the 5th SHIFT cycle: frame aborted, nothing expected from it.
    send(2'b00, 8'hC3, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ss_n", SS_n, 1);
    chk("midrst_mosi", MOSI, 0);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

`ifdef SPI_MASTER_ORDER_CHK_EN
    err_q.push_back(1'b1);
    send(2'b01, 8'h55, 1'b0);
`else
    push_frame(12'h155, 1'b0, 8'h00);
    send(2'b01, 8'h55, 1'b0);
`endif
    push_frame(12'h012, 1'b0, 8'h00); send(2'b00, 8'h12, 1'b0);
    push_frame(12'h134, 1'b0, 8'h00); send(2'b01, 8'h34, 1'b0);
    push_frame(12'h612, 1'b0, 8'h00); send(2'b10, 8'h12, 1'b0);
    push_frame(12'h700, 1'b1, 8'h34); send(2'b11, 8'h00, 1'b0);
    drain();

    chk("exp_q_empty", exp_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    chk("accept_count", n_acc, n_sent);
    chk("sent_count", n_sent, 12);
    chk("ready_low_while_busy", busy_viol, 0);
    chk("b2b_gap_seen", gap_done, 1);
    chk("final_rx_data_held", rx_data, 8'h34);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
